unary_operand_driver: RTL



---
 rtl/unary_operand_driver_if.sv | 42 ++++
 rtl/unary_operand_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/unary_operand_driver_if.sv
// Bundle between unary_operand_driver, its controller and the unary adder.
// Optional UNARY_DRV_CHECK_EN adds the self-check mismatch flag.
interface unary_operand_driver_if #(
    parameter int unsigned W = 4
);
    // Controller side
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
`ifdef UNARY_DRV_CHECK_EN
    logic         mismatch;
`endif
    // Adder side
    logic         A;
    logic         B;
    logic         en;
    logic         read_or_write;
    logic         dout;
    logic         C;

    // Driver view
    modport master (
        input  start, op_a, op_b, dout, C,
`ifdef UNARY_DRV_CHECK_EN
        output mismatch,
`endif
        output A, B, en, read_or_write, busy, done, result, carry
    );

    // Environment view (controller plus adder)
    modport slave (
        output start, op_a, op_b, dout, C,
`ifdef UNARY_DRV_CHECK_EN
        input  mismatch,
`endif
        input  A, B, en, read_or_write, busy, done, result, carry
    );
endinterface

// File: rtl/unary_operand_driver.sv
// Unary operand driver: streams two binary operands to a unary adder as unary
// bursts, waits for the adder's carry to settle, then drains the unary result
// back to binary. Define UNARY_DRV_CHECK_EN to add the result self-check.
module unary_operand_driver #(
    parameter int unsigned W          = 4,
    parameter int unsigned SETTLE_CYC = 3
) (
    input logic                     clk,
    input logic                     rst_n,
    unary_operand_driver_if.master  bus
);
    // Counter must reach 2^W (drain watchdog) and SETTLE_CYC-1.
    localparam int unsigned CntW = W + 1;
    localparam logic [CntW-1:0] WdLast     = CntW'(2 ** W);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {StIdle, StSend, StSettle, StDrain} state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [W-1:0]    r_op_a, w_op_a_d;
    logic [W-1:0]    r_op_b, w_op_b_d;
    logic [W-1:0]    r_acc, w_acc_d;
    logic [W-1:0]    r_result, w_result_d;
    logic            r_carry, w_carry_d;
    logic            r_busy, w_busy_d;
    logic            r_done, w_done_d;
    logic            r_a, w_a_d;
    logic            r_b, w_b_d;
    logic            r_en, w_en_d;
    logic            r_rw, w_rw_d;
    logic [W-1:0]    w_max;
    logic [W-1:0]    w_acc_inc;

    assign w_max     = (r_op_a > r_op_b) ? r_op_a : r_op_b;
    assign w_acc_inc = r_acc + W'(bus.dout);

    // Next-state, counters, accumulator and registered-output next values
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_op_a_d   = r_op_a;
        w_op_b_d   = r_op_b;
        w_acc_d    = r_acc;
        w_result_d = r_result;
        w_carry_d  = r_carry;
        w_busy_d   = r_busy;
        w_done_d   = 1'b0;

        unique case (r_state)
            StIdle: begin
                // A start coinciding with the done pulse is dropped.
                if (bus.start && !r_done) begin
                    w_op_a_d  = bus.op_a;
                    w_op_b_d  = bus.op_b;
                    w_carry_d = 1'b0;
                    w_busy_d  = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = (bus.op_a == '0 && bus.op_b == '0) ? StSettle : StSend;
                end
            end
            StSend: begin
                w_carry_d = r_carry | bus.C;
                if (r_cnt == CntW'(w_max) - CntW'(1)) begin
                    w_cnt_d   = '0;
                    w_state_d = StSettle;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StSettle: begin
                w_carry_d = r_carry | bus.C;
                if (r_cnt == SettleLast) begin
                    w_cnt_d   = '0;
                    w_acc_d   = '0;
                    w_state_d = StDrain;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StDrain: begin
                w_carry_d = r_carry | bus.C;
                w_acc_d   = w_acc_inc;
                // k=0 is the adder's register lag, so a low dout there is not the end.
                if ((r_cnt != '0 && !bus.dout) || r_cnt == WdLast) begin
                    w_result_d = w_acc_inc;
                    w_done_d   = 1'b1;
                    w_busy_d   = 1'b0;
                    w_cnt_d    = '0;
                    w_state_d  = StIdle;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Stream outputs are registered from the next state and index.
        w_en_d = (w_state_d != StIdle);
        w_rw_d = (w_state_d == StDrain);
        w_a_d  = (w_state_d == StSend) && (w_cnt_d < CntW'(w_op_a_d));
        w_b_d  = (w_state_d == StSend) && (w_cnt_d < CntW'(w_op_b_d));
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_en     <= 1'b0;
            r_rw     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_op_a   <= w_op_a_d;
            r_op_b   <= w_op_b_d;
            r_acc    <= w_acc_d;
            r_result <= w_result_d;
            r_carry  <= w_carry_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_en     <= w_en_d;
            r_rw     <= w_rw_d;
        end
    end

    assign bus.A             = r_a;
    assign bus.B             = r_b;
    assign bus.en            = r_en;
    assign bus.read_or_write = r_rw;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.result        = r_result;
    assign bus.carry         = r_carry;

`ifdef UNARY_DRV_CHECK_EN
    logic [W:0] w_sum;
    logic       w_mismatch_d;
    logic       r_mismatch;

    assign w_sum        = {1'b0, r_op_a} + {1'b0, r_op_b};
    assign w_mismatch_d = w_done_d &&
                          ((w_result_d != w_sum[W-1:0]) || (w_carry_d != w_sum[W]));

    // Self-check flag, valid only in the done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mismatch <= 1'b0;
        else        r_mismatch <= w_mismatch_d;
    end

    assign bus.mismatch = r_mismatch;
`endif

endmodule
